mul_seq: RTL and testbench
==========================

Name: mul_seq

Overview:
- Iterative shift-add multiplier placed directly upstream of the datapath's generic write-enabled N-bit register.
- Takes two N-bit operands and produces the 2N-bit product one operand bit per clock.
- On completion it drives result plus a one-cycle write-enable pulse. The HI/LO holding registers capture the product on the next rising clock edge.
- Used for MUL instructions without a wide combinational multiplier in the single-cycle core; the core stalls on busy.

Parameters:
- N, 32: operand width. Product is 2N bits. N >= 2.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state immediately
- start  input  1  request; sampled only in IDLE
- a  input  N  multiplicand
- b  input  N  multiplier
- is_signed  input  1  present only with SIGNED_MUL_EN; sampled with start
- out_lo  output  N  low half of product; connects to LO register input
- out_hi  output  N  high half of product; connects to HI register input
- we  output  1  one-cycle done pulse; drives the downstream registers' we
- busy  output  1  high while an operation is in progress (RUN or DONE)

Behaviour:
- Reset (async, any state, including mid-operation):
  - state=IDLE, counter=0, internal accumulator/operand registers=0.
  - out_lo=0, out_hi=0, we=0, busy=0.
  - The in-flight operation is discarded; no we pulse is produced for it.
- States:
  - IDLE: busy=0, we=0. If start=1 at edge t0: latch a and b (and is_signed), clear the accumulator, counter=0, go to RUN.
  - RUN: busy=1, we=0. Each edge:
    - if multiplier LSB=1, add the multiplicand into the upper N+1 bits of the accumulator;
    - shift {carry, accumulator, multiplier} right by 1;
    - counter++.
    - After the N-th RUN edge (t0+N), go to DONE.
  - DONE: busy=1, we=1 for exactly this one cycle. {out_hi,out_lo} holds the full product from edge t0+N. At edge t0+N+1 go to IDLE.
- Latency:
  - start accepted at t0 -> we high during cycle [t0+N, t0+N+1).
  - Downstream register captures at edge t0+N+1.
  - Total N+1 cycles start-to-capture.
- Result width rules:
  - Unsigned product, exact: no overflow is possible in 2N bits.
  - Addition carry is kept in the extra accumulator bit, never dropped.
- Outputs:
  - out_hi/out_lo update only on the transition into DONE.
  - They hold the last product in IDLE until the next completion.
  - They never show partial sums.
- start while busy=1 (RUN or DONE): ignored, never queued. A request must be re-asserted once busy=0.
- Operands:
  - a and b may change freely after the start edge; only the latched copies are used.
- Back-to-back: start=1 in the first IDLE cycle after DONE is accepted normally. Minimum issue interval is N+2 cycles.
- Zero operands:
  - A zero operand still takes the full N cycles; no early termination.
  - Result is 0 with a normal we pulse.

Optional Feature:
- Macro: SIGNED_MUL_EN
- Defined:
  - The is_signed port exists.
  - If is_signed=1 at start, a and b are two's complement. Negative operands are negated at latch time and their sign bits XORed.
  - If the XORed sign is 1, the 2N-bit result is negated when written into out_hi/out_lo at the DONE transition.
  - Latency is identical to unsigned.
  - is_signed=0 behaves exactly as the undefined build.
  - Most-negative operands (0x80000000) are handled as magnitude 2^(N-1) without error.
- Undefined: no is_signed port; all operations are unsigned.

Test Plan:
- Reset then idle 5 cycles -> out_hi=0, out_lo=0, we=0, busy=0 throughout.
- N=32, a=0x00000007, b=0x00000006, start one cycle at t0 -> busy=1 from t0, we=1 only in cycle t0+32, out_hi=0, out_lo=0x0000002A.
- a=b=0xFFFFFFFF unsigned -> out_hi=0xFFFFFFFE, out_lo=0x00000001. Then start asserted during RUN -> ignored; exactly one we pulse.
- a=0xFFFFFFFD, b=5:
  - with SIGNED_MUL_EN and is_signed=1 -> out_hi=0xFFFFFFFF, out_lo=0xFFFFFFF1;
  - without the macro -> out_hi=0x00000004, out_lo=0xFFFFFFF1.
- Start a=3,b=4, then reset pulse at t0+10 -> all outputs 0 immediately, no we pulse. Next start a=3,b=4 -> out_lo=0x0000000C after N+1 cycles.
- Back-to-back: second start in the first IDLE cycle after DONE with a=0x80000000, b=2 -> out_hi=0x00000001, out_lo=0; previous result held until the second we.

Source files
------------

// File: rtl/mul_seq_if.sv
// Request/result bundle between the core and the shift-add multiplier.
// The is_signed request bit exists only when SIGNED_MUL_EN is defined.
interface mul_seq_if #(
    parameter int N = 32
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
`ifdef SIGNED_MUL_EN
    logic         is_signed;
`endif
    logic [N-1:0] out_lo;
    logic [N-1:0] out_hi;
    logic         we;
    logic         busy;

    modport master (
        output start,
        output a,
        output b,
`ifdef SIGNED_MUL_EN
        output is_signed,
`endif
        input  out_lo,
        input  out_hi,
        input  we,
        input  busy
    );

    modport slave (
        input  start,
        input  a,
        input  b,
`ifdef SIGNED_MUL_EN
        input  is_signed,
`endif
        output out_lo,
        output out_hi,
        output we,
        output busy
    );
endinterface

// File: rtl/mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit per clock, 2N-bit product, one-cycle we pulse.
// Define SIGNED_MUL_EN to add two's-complement operation selected by is_signed.
module mul_seq #(
    parameter int N = 32
) (
    input  logic      clock,
    input  logic      reset,
    mul_seq_if.slave  bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   mcand_q, mcand_d;
    logic [N-1:0]   hi_q, hi_d;
    logic [N-1:0]   lo_q, lo_d;
    logic           neg_q, neg_d;
    logic [N-1:0]   out_hi_q, out_hi_d;
    logic [N-1:0]   out_lo_q, out_lo_d;

    logic [N-1:0]   op_a, op_b;
    logic           op_neg;
    logic [N:0]     sum;
    logic [2*N-1:0] prod;
    logic [2*N-1:0] prod_out;

`ifdef SIGNED_MUL_EN
    // Magnitudes are latched; 2^(N-1) negates to itself, which is the correct magnitude.
    logic a_neg, b_neg;
    assign a_neg  = bus.is_signed & bus.a[N-1];
    assign b_neg  = bus.is_signed & bus.b[N-1];
    assign op_a   = a_neg ? -bus.a : bus.a;
    assign op_b   = b_neg ? -bus.b : bus.b;
    assign op_neg = a_neg ^ b_neg;
`else
    assign op_a   = bus.a;
    assign op_b   = bus.b;
    assign op_neg = 1'b0;
`endif

    // The extra sum bit holds the carry so it is shifted into the high half, never dropped.
    assign sum      = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(N+1){1'b0}});
    assign prod     = {sum[N:1], sum[0], lo_q[N-1:1]};
    assign prod_out = neg_q ? -prod : prod;

    always_comb begin
        // NOTE: every variable gets its hold value first so no path infers a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        neg_d    = neg_q;
        out_hi_d = out_hi_q;
        out_lo_d = out_lo_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mcand_d = op_a;
                    lo_d    = op_b;
                    hi_d    = '0;
                    cnt_d   = '0;
                    neg_d   = op_neg;
                    state_d = RUN;
                end
            end
            RUN: begin
                hi_d  = prod[2*N-1:N];
                lo_d  = prod[N-1:0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    out_hi_d = prod_out[2*N-1:N];
                    out_lo_d = prod_out[N-1:0];
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            neg_q    <= 1'b0;
            out_hi_q <= '0;
            out_lo_q <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of the others.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            neg_q    <= neg_d;
            out_hi_q <= out_hi_d;
            out_lo_q <= out_lo_d;
        end
    end

    assign bus.out_hi = out_hi_q;
    assign bus.out_lo = out_lo_q;
    assign bus.we     = (state_q == DONE);
    assign bus.busy   = (state_q != IDLE);
endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq: timing of busy/we, product values, ignored starts, async reset.
// Signed vectors are exercised when SIGNED_MUL_EN is defined.
module tb_mul_seq;
    localparam int N = 32;

    logic clock = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [2*N-1:0] last_prod;

    mul_seq_if #(.N(N)) bus ();

    mul_seq #(.N(N)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [2*N-1:0] got, input logic [2*N-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; drives start there and leaves at the negedge of the first IDLE cycle.
    task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic sgn, input logic [2*N-1:0] exp, input bit poke);
        int    we_cnt    = 0;
        int    we_at     = -1;
        int    busy_bad  = 0;
        int    hold_bad  = 0;
        string t         = {tag, sgn ? "/s" : "/u"};
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
`ifdef SIGNED_MUL_EN
        bus.is_signed = sgn;
`endif
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        bus.a     = ~a;
        bus.b     = a ^ b ^ 32'h5A5A_A5A5;
`ifdef SIGNED_MUL_EN
        bus.is_signed = ~sgn;
`endif
        for (int j = 0; j <= N + 1; j++) begin
            @(negedge clock);
            if (bus.we) begin
                we_cnt++;
                we_at = j;
            end
            if (bus.busy !== (j <= N)) busy_bad++;
            if (j < N && {bus.out_hi, bus.out_lo} !== last_prod) hold_bad++;
            if (j == N) check({t, " product"}, {bus.out_hi, bus.out_lo}, exp);
            if (poke && j == 5) bus.start = 1'b1;
            if (poke && j == 8) bus.start = 1'b0;
        end
        check({t, " busy_bad_cycles"}, 64'(busy_bad), 64'd0);
        check({t, " we_pulses"}, 64'(we_cnt), 64'd1);
        check({t, " we_cycle"}, 64'(we_at), 64'(N));
        check({t, " hold_bad_cycles"}, 64'(hold_bad), 64'd0);
        last_prod = exp;
    endtask

    initial begin
        int we_cnt;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
`ifdef SIGNED_MUL_EN
        bus.is_signed = 1'b0;
`endif
        last_prod = '0;
        #1;
        check("reset out", {bus.out_hi, bus.out_lo}, 64'd0);
        check("reset we_busy", 64'({bus.we, bus.busy}), 64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("idle out", {bus.out_hi, bus.out_lo}, 64'd0);
            check("idle we_busy", 64'({bus.we, bus.busy}), 64'd0);
        end

        run_op("7x6", 32'h0000_0007, 32'h0000_0006, 1'b0, 64'h0000_0000_0000_002A, 1'b0);
        @(negedge clock);
        run_op("ffxff_poke", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b1);
        @(negedge clock);
        // A start raised mid-run must not have queued a second operation.
        check("no_restart busy", 64'(bus.busy), 64'd0);
`ifdef SIGNED_MUL_EN
        run_op("m3x5", 32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
        @(negedge clock);
        run_op("m3x5", 32'hFFFF_FFFD, 32'h0000_0005, 1'b0, 64'h0000_0004_FFFF_FFF1, 1'b0);
        @(negedge clock);
        run_op("minxmin", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 1'b0);
        @(negedge clock);
        run_op("m2x3", 32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0);
        @(negedge clock);
`else
        run_op("m3x5", 32'hFFFF_FFFD, 32'h0000_0005, 1'b0, 64'h0000_0004_FFFF_FFF1, 1'b0);
        @(negedge clock);
`endif
        run_op("0xb", 32'h0000_0000, 32'h1234_5678, 1'b0, 64'h0000_0000_0000_0000, 1'b0);
        @(negedge clock);
        run_op("shift4", 32'h1234_5678, 32'h0000_0010, 1'b0, 64'h0000_0001_2345_6780, 1'b0);
        @(negedge clock);

        // Reset at edge t0+10 of an in-flight 3x4.
        bus.start = 1'b1;
        bus.a     = 32'd3;
        bus.b     = 32'd4;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("midreset out", {bus.out_hi, bus.out_lo}, 64'd0);
        check("midreset we_busy", 64'({bus.we, bus.busy}), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        we_cnt = 0;
        for (int j = 0; j < N + 3; j++) begin
            @(negedge clock);
            if (bus.we) we_cnt++;
        end
        check("midreset we_pulses", 64'(we_cnt), 64'd0);
        check("midreset busy", 64'(bus.busy), 64'd0);
        last_prod = '0;

        run_op("3x4", 32'd3, 32'd4, 1'b0, 64'h0000_0000_0000_000C, 1'b0);
        run_op("b2b", 32'h8000_0000, 32'd2, 1'b0, 64'h0000_0001_0000_0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
